// File: rtl/tx_bram_playback_controller.sv
// tx_bram_playback_controller: BRAM sample loader with tick-paced playback; define TX_LOOP_EN for continuous looping
module tx_bram_playback_controller #(
  parameter int MEMORY_LENGTH = 510,
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 16
) (
  input  logic                         ctx_clk,
  input  logic                         rtx_rst,
  input  logic                         etx_en,
  input  logic                         load_en,
  input  logic signed [DATA_WIDTH-1:0] data_in_load,
  input  logic                         clear_trig,
  input  logic                         start_trig,
  input  logic                         stop_trig,
  input  logic                         sample_tick,
  output logic signed [DATA_WIDTH-1:0] data_out,
  output logic                         data_valid,
  output logic                         busy,
  output logic                         done,
  output logic                         load_ovf
);
  typedef enum logic {IDLE, PLAY} state_t;
  localparam logic [ADDR_WIDTH-1:0] last_addr = ADDR_WIDTH'(MEMORY_LENGTH - 1);
  localparam logic [ADDR_WIDTH:0] full_len = (ADDR_WIDTH + 1)'(MEMORY_LENGTH);
  state_t state;
  logic signed [DATA_WIDTH-1:0] mem [MEMORY_LENGTH];
  logic [ADDR_WIDTH-1:0] wr_addr, rd_addr;
  logic [ADDR_WIDTH:0] stored_len, play_cnt;
  logic idle, go, wr, tick, last, full;
  always_comb begin
    idle = state == IDLE;
    go = etx_en && idle && start_trig && !clear_trig && stored_len != '0;
    wr = etx_en && idle && load_en && !clear_trig && !go;
    tick = etx_en && !idle && sample_tick && !stop_trig;
    last = play_cnt + 1'b1 == stored_len;
    full = stored_len == full_len;
  end
  always_ff @(posedge ctx_clk)
    if (wr) mem[wr_addr] <= data_in_load;
  always_ff @(posedge ctx_clk) begin
    if (rtx_rst) begin
      state <= IDLE;
      wr_addr <= '0;
      rd_addr <= '0;
      stored_len <= '0;
      play_cnt <= '0;
      data_out <= '0;
      data_valid <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      load_ovf <= 1'b0;
    end else if (!etx_en) begin
      data_valid <= 1'b0;
      done <= 1'b0;
    end else begin
      data_valid <= tick;
      done <= 1'b0;
      if (tick) data_out <= mem[rd_addr];
      if (idle) begin
        if (clear_trig) begin
          wr_addr <= '0;
          stored_len <= '0;
          load_ovf <= 1'b0;
        end else if (go) begin
          state <= PLAY;
          busy <= 1'b1;
          rd_addr <= '0;
          play_cnt <= '0;
        end else if (wr) begin
          wr_addr <= wr_addr == last_addr ? '0 : wr_addr + 1'b1;
          stored_len <= full ? full_len : stored_len + 1'b1;
          if (full) load_ovf <= 1'b1;
        end
      end else if (stop_trig) begin
        state <= IDLE;
        busy <= 1'b0;
        done <= 1'b1;
      end else if (tick) begin
        if (last) begin
`ifdef TX_LOOP_EN
          rd_addr <= '0;
          play_cnt <= '0;
`else
          state <= IDLE;
          busy <= 1'b0;
          done <= 1'b1;
`endif
        end else begin
          rd_addr <= rd_addr == last_addr ? '0 : rd_addr + 1'b1;
          play_cnt <= play_cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_tx_bram_playback_controller.sv
// tb_tx_bram_playback_controller: directed self-checking bench for tx_bram_playback_controller
module tb_tx_bram_playback_controller;
  logic clk = 1'b0;
  logic rst, en, load_en, clear_trig, start_trig, stop_trig, sample_tick;
  logic signed [15:0] din;
  logic signed [15:0] data_out;
  logic data_valid, busy, done, load_ovf;
  int passed = 0;
  int total = 0;

  tx_bram_playback_controller dut (
    .ctx_clk(clk), .rtx_rst(rst), .etx_en(en), .load_en(load_en), .data_in_load(din),
    .clear_trig(clear_trig), .start_trig(start_trig), .stop_trig(stop_trig),
    .sample_tick(sample_tick), .data_out(data_out), .data_valid(data_valid),
    .busy(busy), .done(done), .load_ovf(load_ovf)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic signed [15:0] v);
    load_en = 1'b1;
    din = v;
    cyc();
    load_en = 1'b0;
  endtask

  task automatic clear();
    clear_trig = 1'b1;
    cyc();
    clear_trig = 1'b0;
  endtask

  task automatic start();
    start_trig = 1'b1;
    cyc();
    start_trig = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    total++;
    if (data_out !== 16'sd0 || data_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || load_ovf !== 1'b0)
      $display("FAIL reset: out=%0d valid=%b busy=%b done=%b ovf=%b expected all 0", data_out, data_valid, busy, done, load_ovf);
    else passed++;
  endtask

  task automatic test_empty_start();
    logic bad = 1'b0;
    start_trig = 1'b1;
    sample_tick = 1'b1;
    cyc();
    start_trig = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (busy !== 1'b0 || data_valid !== 1'b0 || done !== 1'b0) bad = 1'b1;
      cyc();
    end
    sample_tick = 1'b0;
    total++;
    if (bad) $display("FAIL empty_start: busy=%b valid=%b done=%b expected all 0", busy, data_valid, done);
    else passed++;
  endtask

  task automatic test_playback();
    logic signed [15:0] exp_v [5] = '{16'sd100, -16'sd200, 16'sd300, -16'sd400, 16'sd500};
    clear();
    foreach (exp_v[k]) load(exp_v[k]);
    start();
    total++;
    if (busy !== 1'b1) $display("FAIL play_busy: busy=%b expected 1", busy);
    else passed++;
    for (int k = 0; k < 5; k++) begin
      logic bad = 1'b0;
      sample_tick = 1'b1;
      cyc();
      sample_tick = 1'b0;
      total++;
      if (data_valid !== 1'b1 || data_out !== exp_v[k] || done !== (k == 4))
        $display("FAIL play_%0d: valid=%b out=%0d done=%b expected valid=1 out=%0d done=%b", k, data_valid, data_out, done, exp_v[k], k == 4);
      else passed++;
      for (int j = 0; j < 3; j++) begin
        cyc();
        if (data_valid !== 1'b0 || done !== 1'b0 || data_out !== exp_v[k]) bad = 1'b1;
      end
      total++;
      if (bad) $display("FAIL play_hold_%0d: valid=%b done=%b out=%0d expected valid=0 done=0 out=%0d", k, data_valid, done, data_out, exp_v[k]);
      else passed++;
    end
    total++;
    if (busy !== 1'b0) $display("FAIL play_end_busy: busy=%b expected 0", busy);
    else passed++;
  endtask

  task automatic test_overflow();
    logic bad = 1'b0;
    int bad_i = 0;
    logic signed [15:0] bad_v = 0;
    logic signed [15:0] e;
    clear();
    load_en = 1'b1;
    for (int i = 0; i < 512; i++) begin
      din = 16'(i);
      cyc();
      if (i == 509) begin
        total++;
        if (load_ovf !== 1'b0) $display("FAIL ovf_full: ovf=%b expected 0", load_ovf);
        else passed++;
      end
    end
    load_en = 1'b0;
    total++;
    if (load_ovf !== 1'b1) $display("FAIL ovf_set: ovf=%b expected 1", load_ovf);
    else passed++;
    start();
    sample_tick = 1'b1;
    for (int i = 0; i < 510; i++) begin
      cyc();
      e = i == 0 ? 16'sd510 : i == 1 ? 16'sd511 : 16'(i);
      if (!bad && (data_valid !== 1'b1 || data_out !== e || done !== (i == 509))) begin
        bad = 1'b1;
        bad_i = i;
        bad_v = data_out;
      end
    end
    sample_tick = 1'b0;
    total++;
    if (bad) $display("FAIL ovf_play: index %0d out=%0d expected %0d (valid each tick, done at last)", bad_i, bad_v, bad_i == 0 ? 510 : bad_i == 1 ? 511 : bad_i);
    else passed++;
    cyc();
    total++;
    if (busy !== 1'b0 || data_valid !== 1'b0) $display("FAIL ovf_end: busy=%b valid=%b expected 0 0", busy, data_valid);
    else passed++;
  endtask

  task automatic test_reset_mid_play();
    logic bad = 1'b0;
    clear();
    load(16'sd10);
    load(16'sd20);
    load(16'sd30);
    start();
    sample_tick = 1'b1;
    cyc();
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    sample_tick = 1'b0;
    total++;
    if (data_out !== 16'sd0 || data_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || load_ovf !== 1'b0)
      $display("FAIL rst_mid: out=%0d valid=%b busy=%b done=%b ovf=%b expected all 0", data_out, data_valid, busy, done, load_ovf);
    else passed++;
    start();
    for (int i = 0; i < 3; i++) begin
      if (busy !== 1'b0) bad = 1'b1;
      cyc();
    end
    total++;
    if (bad) $display("FAIL rst_start_ignored: busy=%b expected 0", busy);
    else passed++;
    load(-16'sd7);
    start();
    sample_tick = 1'b1;
    cyc();
    sample_tick = 1'b0;
    total++;
    if (data_valid !== 1'b1 || data_out !== -16'sd7 || done !== 1'b1 || busy !== 1'b0)
      $display("FAIL rst_reload_single: valid=%b out=%0d done=%b busy=%b expected 1 -7 1 0", data_valid, data_out, done, busy);
    else passed++;
  endtask

  task automatic test_enable_gate();
    clear();
    load(16'sd1);
    load(16'sd2);
    load(16'sd3);
    start();
    sample_tick = 1'b1;
    cyc();
    total++;
    if (data_valid !== 1'b1 || data_out !== 16'sd1) $display("FAIL en_first: valid=%b out=%0d expected 1 1", data_valid, data_out);
    else passed++;
    en = 1'b0;
    cyc();
    total++;
    if (data_valid !== 1'b0 || data_out !== 16'sd1 || busy !== 1'b1) $display("FAIL en_disabled: valid=%b out=%0d busy=%b expected 0 1 1", data_valid, data_out, busy);
    else passed++;
    en = 1'b1;
    cyc();
    total++;
    if (data_valid !== 1'b1 || data_out !== 16'sd2 || done !== 1'b0) $display("FAIL en_second: valid=%b out=%0d done=%b expected 1 2 0", data_valid, data_out, done);
    else passed++;
    cyc();
    sample_tick = 1'b0;
    total++;
    if (data_valid !== 1'b1 || data_out !== 16'sd3 || done !== 1'b1 || busy !== 1'b0) $display("FAIL en_third: valid=%b out=%0d done=%b busy=%b expected 1 3 1 0", data_valid, data_out, done, busy);
    else passed++;
  endtask

  task automatic test_loop();
    logic signed [15:0] exp_v [7] = '{16'sd1, 16'sd2, 16'sd3, 16'sd1, 16'sd2, 16'sd3, 16'sd1};
    clear();
    load(16'sd1);
    load(16'sd2);
    load(16'sd3);
    start();
    sample_tick = 1'b1;
    foreach (exp_v[k]) begin
      cyc();
      total++;
      if (data_valid !== 1'b1 || data_out !== exp_v[k] || done !== 1'b0 || busy !== 1'b1)
        $display("FAIL loop_%0d: valid=%b out=%0d done=%b busy=%b expected 1 %0d 0 1", k, data_valid, data_out, done, busy, exp_v[k]);
      else passed++;
    end
    sample_tick = 1'b0;
    stop_trig = 1'b1;
    cyc();
    stop_trig = 1'b0;
    total++;
    if (done !== 1'b1 || busy !== 1'b0) $display("FAIL loop_stop: done=%b busy=%b expected 1 0", done, busy);
    else passed++;
  endtask

  task automatic test_stop();
    clear();
    load(16'sd4);
    load(16'sd5);
    load(16'sd6);
    start();
    sample_tick = 1'b1;
    cyc();
    stop_trig = 1'b1;
    total++;
    if (data_valid !== 1'b1 || data_out !== 16'sd4) $display("FAIL stop_inflight: valid=%b out=%0d expected 1 4", data_valid, data_out);
    else passed++;
    cyc();
    stop_trig = 1'b0;
    sample_tick = 1'b0;
    total++;
    if (done !== 1'b1 || busy !== 1'b0 || data_valid !== 1'b0 || data_out !== 16'sd4)
      $display("FAIL stop_done: done=%b busy=%b valid=%b out=%0d expected 1 0 0 4", done, busy, data_valid, data_out);
    else passed++;
    cyc();
    total++;
    if (done !== 1'b0) $display("FAIL stop_pulse: done=%b expected 0", done);
    else passed++;
  endtask

  initial begin
    rst = 1'b1;
    en = 1'b1;
    load_en = 1'b0;
    clear_trig = 1'b0;
    start_trig = 1'b0;
    stop_trig = 1'b0;
    sample_tick = 1'b0;
    din = '0;
    test_reset();
    test_empty_start();
`ifdef TX_LOOP_EN
    test_loop();
`else
    test_playback();
    test_overflow();
    test_reset_mid_play();
    test_enable_gate();
`endif
    test_stop();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
